// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types for the L2 writeback path: word, line,
// line tag and the memory-port state encoding.
package lc3b_types;
  localparam int unsigned TAG_W = 11;

  typedef logic [15:0]      lc3b_word;
  typedef logic [255:0]     lc3b_full_chunk;
  typedef logic [TAG_W-1:0] lc3b_tag;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_READ  = 2'd1,
    P_WRITE = 2'd2
  } port_state_e;

  // Rebuild a line-aligned byte address from a line tag.
  function automatic lc3b_word line_addr(input lc3b_tag tag);
    return {tag, 5'b00000};
  endfunction
endpackage

// File: rtl/l2_writeback_buffer_checker.sv
// Protocol properties for l2_writeback_buffer's memory and fill ports.
module l2_writeback_buffer_checker (
  input logic         clk,
  input logic         reset_n,
  input logic         pmem_read,
  input logic         pmem_write,
  input logic         fill_resp,
  input logic [255:0] fill_rdata
);

  // Memory commands are mutually exclusive.
  pmem_cmd_exclusive_a : assert property (@(posedge clk) disable iff (!reset_n)
    !(pmem_read && pmem_write));

  // Fill data is quiet unless a response is being returned.
  fill_rdata_quiet_a : assert property (@(posedge clk) disable iff (!reset_n)
    !fill_resp |-> (fill_rdata == 256'h0));

endmodule

// File: rtl/wb_entry.sv
// Single writeback entry: valid/tag/data storage plus the fill-hit comparator.
// The payload is frozen while valid so a pending drain can never be corrupted.
module wb_entry
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           capture,
  input  logic           clear,
  input  lc3b_tag        capture_tag,
  input  lc3b_full_chunk capture_data,
  input  lc3b_tag        lookup_tag,
  output logic           valid,
  output lc3b_tag        tag,
  output lc3b_full_chunk data,
  output logic           hit
);

  logic           valid_r;
  lc3b_tag        tag_r;
  lc3b_full_chunk data_r;
  logic           load_s;

  assign load_s = capture && !valid_r;

  // Entry storage: valid set on capture, cleared on drain; payload loads only when empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      tag_r   <= {TAG_W{1'b0}};
      data_r  <= 256'h0;
    end else begin
      if (clear) begin
        valid_r <= 1'b0;
      end else if (load_s) begin
        valid_r <= 1'b1;
      end else begin
        valid_r <= valid_r;
      end
      if (load_s) begin
        tag_r  <= capture_tag;
        data_r <= capture_data;
      end else begin
        tag_r  <= tag_r;
        data_r <= data_r;
      end
    end
  end

  assign valid = valid_r;
  assign tag   = tag_r;
  assign data  = data_r;
  assign hit   = valid_r && (tag_r == lookup_tag);

endmodule

// File: rtl/l2_writeback_buffer.sv
// One-line victim buffer between L2 and physical memory. Fill hits are served
// from the buffer in the same cycle; misses take priority over draining.
module l2_writeback_buffer
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           evict_valid,
  input  lc3b_word       evict_addr,
  input  lc3b_full_chunk evict_data,
  output logic           evict_ready,
  input  logic           fill_req,
  input  lc3b_word       fill_addr,
  output logic           fill_resp,
  output lc3b_full_chunk fill_rdata,
  output logic           pmem_read,
  output logic           pmem_write,
  output lc3b_word       pmem_address,
  output lc3b_full_chunk pmem_wdata,
  input  lc3b_full_chunk pmem_rdata,
  input  logic           pmem_resp
);

  port_state_e    state_r;
  port_state_e    state_next_s;
  logic           valid_s;
  logic           hit_s;
  logic           clear_s;
  lc3b_tag        tag_s;
  lc3b_full_chunk data_s;
  logic           unused_addr_bits_s;

  // Offset bits within a line carry no meaning for this buffer.
  assign unused_addr_bits_s = ^{evict_addr[4:0], fill_addr[4:0]};

  assign clear_s     = (state_r == P_WRITE) && pmem_resp;
  assign evict_ready = ~valid_s;

  wb_entry u_entry (
    .clk          (clk),
    .reset_n      (reset_n),
    .capture      (evict_valid),
    .clear        (clear_s),
    .capture_tag  (evict_addr[15:5]),
    .capture_data (evict_data),
    .lookup_tag   (fill_addr[15:5]),
    .valid        (valid_s),
    .tag          (tag_s),
    .data         (data_s),
    .hit          (hit_s)
  );

  // Port state register; reset abandons any in-flight memory transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= P_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and port outputs; pmem commands depend on state only.
  always_comb begin
    state_next_s = state_r;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    pmem_wdata   = 256'h0;
    fill_resp    = 1'b0;
    fill_rdata   = 256'h0;
    case (state_r)
      P_IDLE: begin
        if (fill_req && hit_s) begin
          fill_resp  = 1'b1;
          fill_rdata = data_s;
        end else if (fill_req) begin
          state_next_s = P_READ;
        end else if (valid_s) begin
          state_next_s = P_WRITE;
        end else begin
          state_next_s = P_IDLE;
        end
      end
      P_READ: begin
        pmem_read    = 1'b1;
        pmem_address = line_addr(fill_addr[15:5]);
        if (pmem_resp) begin
          fill_resp    = 1'b1;
          fill_rdata   = pmem_rdata;
          state_next_s = P_IDLE;
        end else begin
          state_next_s = P_READ;
        end
      end
      P_WRITE: begin
        pmem_write   = 1'b1;
        pmem_address = line_addr(tag_s);
        pmem_wdata   = data_s;
        if (pmem_resp) begin
          state_next_s = P_IDLE;
        end else begin
          state_next_s = P_WRITE;
        end
      end
      default: begin
        state_next_s = P_IDLE;
      end
    endcase
  end

endmodule

// File: doc/l2_writeback_buffer.md
L2_WRITEBACK_BUFFER -- requirements
Module: l2_writeback_buffer

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low; ports listed below, clock and reset first.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 evict_valid  input  1  L2 presents a dirty victim line.
REQ-005 evict_addr  input  16 (lc3b_word)  victim line address; bits [4:0] ignored.
REQ-006 evict_data  input  256 (lc3b_full_chunk)  victim line data.
REQ-007 evict_ready  output  1  buffer can capture a victim this cycle.
REQ-008 fill_req  input  1  L2 miss fill request, held until fill_resp.
REQ-009 fill_addr  input  16  miss address; bits [4:0] ignored.
REQ-010 fill_resp  output  1  one-cycle pulse; fill_rdata valid.
REQ-011 fill_rdata  output  256  line returned to L2.
REQ-012 pmem_read, pmem_write  output  1 each  physical memory commands.
REQ-013 pmem_address  output  16  line-aligned address, bits [4:0] = 0.
REQ-014 pmem_wdata  output  256  drained line data.
REQ-015 pmem_rdata  input  256; pmem_resp  input  1  memory completion.

Function
REQ-016 Storage SHALL be one entry: valid bit, tag = addr[15:5] (11 bits), 256-bit data.
REQ-017 evict_ready SHALL equal ~valid; capture occurs when evict_valid & evict_ready; valid set next cycle.
REQ-018 Port FSM states SHALL be P_IDLE, P_READ, P_WRITE.
REQ-019 P_IDLE priority: (1) fill_req & valid & tag==fill_addr[15:5] -> fill_resp=1, fill_rdata=buffer data same cycle, stay P_IDLE, entry stays valid; (2) fill_req otherwise -> P_READ; (3) valid -> P_WRITE; (4) else stay.
REQ-020 P_READ: pmem_read=1, pmem_address={fill_addr[15:5],5'b0}; on pmem_resp, fill_resp=1, fill_rdata=pmem_rdata same cycle, -> P_IDLE.
REQ-021 P_WRITE: pmem_write=1, pmem_address={tag,5'b0}, pmem_wdata=buffer data; on pmem_resp clear valid, -> P_IDLE.
REQ-022 pmem_read and pmem_write SHALL never be asserted together; both SHALL be Moore outputs of the FSM.
REQ-023 fill_req arriving during P_WRITE SHALL wait for drain completion; it is then serviced from P_IDLE via P_READ (buffer no longer valid).
REQ-024 Capture and fill_req in the same cycle: hit compare uses registered entry only; newly captured line is not forwarded that cycle.
REQ-025 Buffer data/tag SHALL NOT change while valid (evict_ready=0 guarantees this).
REQ-026 fill_rdata SHALL be 0 when fill_resp=0.

Reset
REQ-027 reset_n low SHALL force: valid=0, state P_IDLE, pmem_read=0, pmem_write=0, fill_resp=0, evict_ready=1, pmem_address=0, pmem_wdata=0, fill_rdata=0.
REQ-028 Reset mid-read or mid-write SHALL abandon the transaction; buffered line is discarded; pmem_resp after reset with FSM in P_IDLE is ignored.

Structure
REQ-029 lc3b_word, lc3b_full_chunk and a 3-value port-state enum SHALL live in lc3b_types; tag width constant (11) likewise.
REQ-030 One sub-module natural: wb_entry (valid/tag/data register plus tag comparator); FSM stays in top.

Verification
REQ-031 Capture addr 0x1234, data D1 -> evict_ready=0 next cycle; P_WRITE with pmem_address=0x1220, pmem_wdata=D1; pmem_resp after 3 cycles -> valid=0, evict_ready=1.
REQ-032 Entry 0x1220 valid, fill_req addr 0x123E -> fill_resp same cycle, fill_rdata=D1, no pmem_read, entry still drained afterward.
REQ-033 Entry 0x1220 valid, fill_req addr 0x4000 in P_IDLE -> P_READ first (pmem_address=0x4000), fill_resp with pmem_rdata, then P_WRITE of 0x1220.
REQ-034 fill_req 0x4000 asserted during P_WRITE -> no pmem_read until write pmem_resp; then P_READ 0x4000.
REQ-035 reset_n low mid-P_WRITE -> pmem_write=0 immediately, valid=0, evict_ready=1; later stray pmem_resp causes no fill_resp.
REQ-036 evict_valid held while valid=1 -> no overwrite; assertion checks pmem_read&pmem_write never both 1.
